// File: rtl/pcjr_peripherals.sv
// rtl/pcjr_peripherals.sv - PCjr I/O peripheral cluster: decode, 8253 subset, port B, PS/2 keyboard, DCSG handshake, audio mix
module pit_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       pclk_enable,
    input  logic       gate,
    input  logic       ctrl_wr,
    input  logic [1:0] ctrl_rw,
    input  logic       data_wr,
    input  logic [7:0] data_in,
    input  logic       data_rd,
    output logic [7:0] rd_data,
    output logic       out
);
    logic [1:0]  rw_mode;
    logic        msb_next;
    logic [7:0]  lsb_hold;
    logic [15:0] reload;
    logic [16:0] count;
    logic        running;
    logic        latched;
    logic [15:0] latch_val;
    logic        load_now;
    logic [15:0] load_val;
    logic [16:0] reload_eff;
    logic [15:0] rd_val;
    logic        rd_msb;

    // A reload of zero stands for 65536, hence the 17-bit count.
    assign reload_eff = (reload == 16'h0000) ? 17'h10000 : {1'b0, reload};
    assign rd_val     = latched ? latch_val : count[15:0];
    assign rd_msb     = (rw_mode == 2'b10) || ((rw_mode == 2'b11) && msb_next);
    assign rd_data    = rd_msb ? rd_val[15:8] : rd_val[7:0];
    assign out        = count > {1'b0, reload_eff[16:1]};

    always_comb begin
        load_now = 1'b0;
        load_val = 16'h0000;
        if (data_wr && !ctrl_wr) begin
            case (rw_mode)
                2'b01: begin
                    load_now = 1'b1;
                    load_val = {8'h00, data_in};
                end
                2'b10: begin
                    load_now = 1'b1;
                    load_val = {data_in, 8'h00};
                end
                2'b11: begin
                    load_now = msb_next;
                    load_val = {data_in, lsb_hold};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rw_mode   <= 2'b11;
            msb_next  <= 1'b0;
            lsb_hold  <= 8'h00;
            reload    <= 16'h0000;
            count     <= 17'h00000;
            running   <= 1'b0;
            latched   <= 1'b0;
            latch_val <= 16'h0000;
        end else begin
            if (running && gate && pclk_enable)
                count <= (count <= 17'd1) ? reload_eff : count - 17'd1;
            if (ctrl_wr) begin
                if (ctrl_rw == 2'b00) begin
                    latched   <= 1'b1;
                    latch_val <= count[15:0];
                end else begin
                    rw_mode  <= ctrl_rw;
                    running  <= 1'b0;
                    msb_next <= 1'b0;
                    latched  <= 1'b0;
                end
            end else if (data_wr) begin
                if (rw_mode == 2'b11) begin
                    msb_next <= ~msb_next;
                    if (!msb_next)
                        lsb_hold <= data_in;
                end
                if (load_now) begin
                    reload  <= load_val;
                    count   <= (load_val == 16'h0000) ? 17'h10000 : {1'b0, load_val};
                    running <= 1'b1;
                end
            end else if (data_rd) begin
                if (rw_mode == 2'b11)
                    msb_next <= ~msb_next;
                if (latched && ((rw_mode != 2'b11) || msb_next))
                    latched <= 1'b0;
            end
        end
    end
endmodule

module pcjr_peripherals #(
    parameter logic [15:0] kb_bit_phase_cycle = 16'd1999,
    parameter logic [15:0] kb_over_time       = 16'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_clock_posedge,
    input  logic        cpu_clock_negedge,
    input  logic        pclk_enable,
    input  logic        dcsg_clock_enable,
    input  logic [19:0] ADDRESS,
    input  logic [7:0]  DATA_IN,
    output logic [7:0]  DATA_OUT,
    input  logic        X_IO_OR_M,
    input  logic        R_OR_DT,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic        MEMR_N,
    input  logic        MEMW_N,
    input  logic        IO_E,
    output logic        SOUND_READY,
    output logic        peripherals_data_out,
    output logic        timer_intr,
    output logic        timer_audio,
    input  logic [7:0]  audio_input,
    output logic [7:0]  audio,
    input  logic        kbd_ps2_device_clock,
    input  logic        kbd_ps2_device_data,
    output logic        NMI
);
    logic [7:0]  port;
    logic        port_hit;
    logic        decoded;
    logic        wr_done;
    logic        wr_commit;
    logic        rd_pending;
    logic [7:0]  rd_port;
    logic        rd_done;
    logic [7:0]  rd_mux;
    logic [7:0]  port_b;
    logic        nmi_en;
    logic [7:0]  scancode;
    logic        key_pending;
    logic [5:0]  dcsg_cnt;
    logic [7:0]  t0_rd, t2_rd;
    logic        t0_out, t2_out;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, cpu_clock_posedge, R_OR_DT, MEMR_N, MEMW_N, ADDRESS[19:16]};

    assign port = ADDRESS[7:0];

    always_comb begin
        port_hit = 1'b0;
        rd_mux   = 8'h00;
        case (port)
            8'h40: begin port_hit = 1'b1; rd_mux = t0_rd; end
            8'h42: begin port_hit = 1'b1; rd_mux = t2_rd; end
            8'h43: port_hit = 1'b1;
            8'h60: begin port_hit = 1'b1; rd_mux = scancode; end
            8'h61: begin port_hit = 1'b1; rd_mux = port_b; end
            8'hA0: begin port_hit = 1'b1; rd_mux = {nmi_en, 6'b000000, key_pending}; end
            8'hC0: port_hit = 1'b1;
            default: ;
        endcase
    end

    assign decoded   = IO_E && X_IO_OR_M && (ADDRESS[15:8] == 8'h00) && port_hit;
    assign wr_commit = decoded && !IOW_N && cpu_clock_negedge && !wr_done;
    // Read side effects fire on the cycle IOR_N is seen high again after a decoded read.
    assign rd_done   = rd_pending && IOR_N;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_done              <= 1'b0;
            rd_pending           <= 1'b0;
            rd_port              <= 8'h00;
            DATA_OUT             <= 8'h00;
            peripherals_data_out <= 1'b0;
            port_b               <= 8'h00;
            nmi_en               <= 1'b0;
            dcsg_cnt             <= 6'd0;
            NMI                  <= 1'b0;
            audio                <= 8'h00;
        end else begin
            if (IOW_N)
                wr_done <= 1'b0;
            else if (wr_commit)
                wr_done <= 1'b1;

            if (decoded && !IOR_N) begin
                rd_pending           <= 1'b1;
                rd_port              <= port;
                DATA_OUT             <= rd_mux;
                peripherals_data_out <= 1'b1;
            end else begin
                if (IOR_N)
                    rd_pending <= 1'b0;
                DATA_OUT             <= 8'h00;
                peripherals_data_out <= 1'b0;
            end

            if (wr_commit && port == 8'h61)
                port_b <= DATA_IN;
            if (wr_commit && port == 8'hA0)
                nmi_en <= DATA_IN[7];

            if (wr_commit && port == 8'hC0)
                dcsg_cnt <= 6'd32;
            else if (dcsg_clock_enable && dcsg_cnt != 6'd0)
                dcsg_cnt <= dcsg_cnt - 6'd1;

            NMI   <= nmi_en && key_pending;
            audio <= {1'b0, audio_input[7:1]} + (timer_audio ? 8'h3F : 8'h00);
        end
    end

    assign SOUND_READY = (dcsg_cnt == 6'd0);

    pit_counter u_counter0 (
        .clock       (clock),
        .reset       (reset),
        .pclk_enable (pclk_enable),
        .gate        (1'b1),
        .ctrl_wr     (wr_commit && port == 8'h43 && DATA_IN[7:6] == 2'b00),
        .ctrl_rw     (DATA_IN[5:4]),
        .data_wr     (wr_commit && port == 8'h40),
        .data_in     (DATA_IN),
        .data_rd     (rd_done && rd_port == 8'h40),
        .rd_data     (t0_rd),
        .out         (t0_out)
    );

    pit_counter u_counter2 (
        .clock       (clock),
        .reset       (reset),
        .pclk_enable (pclk_enable),
        .gate        (port_b[0]),
        .ctrl_wr     (wr_commit && port == 8'h43 && DATA_IN[7:6] == 2'b10),
        .ctrl_rw     (DATA_IN[5:4]),
        .data_wr     (wr_commit && port == 8'h42),
        .data_in     (DATA_IN),
        .data_rd     (rd_done && rd_port == 8'h42),
        .rd_data     (t2_rd),
        .out         (t2_out)
    );

    assign timer_intr  = t0_out;
    assign timer_audio = t2_out && port_b[1];

    logic [1:0]  kclk_s, kdat_s;
    logic        kclk_f, kdat_f;
    logic [15:0] kclk_cnt, kdat_cnt;
    logic [15:0] phase_cnt;
    logic [15:0] timeout_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        parity_bit;
    logic        kclk_fall;
    logic        phase_tick;

    assign kclk_fall  = kclk_f && !kclk_s[1] && (kclk_cnt == kb_bit_phase_cycle);
    assign phase_tick = (phase_cnt == kb_bit_phase_cycle);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kclk_s      <= 2'b11;
            kdat_s      <= 2'b11;
            kclk_f      <= 1'b1;
            kdat_f      <= 1'b1;
            kclk_cnt    <= 16'h0000;
            kdat_cnt    <= 16'h0000;
            phase_cnt   <= 16'h0000;
            timeout_cnt <= 16'h0000;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            parity_bit  <= 1'b0;
            scancode    <= 8'h00;
            key_pending <= 1'b0;
        end else begin
            kclk_s <= {kclk_s[0], kbd_ps2_device_clock};
            kdat_s <= {kdat_s[0], kbd_ps2_device_data};

            // A line change is taken only once it has held for kb_bit_phase_cycle+1 clocks.
            if (kclk_s[1] == kclk_f)
                kclk_cnt <= 16'h0000;
            else if (kclk_cnt == kb_bit_phase_cycle) begin
                kclk_f   <= kclk_s[1];
                kclk_cnt <= 16'h0000;
            end else
                kclk_cnt <= kclk_cnt + 16'd1;

            if (kdat_s[1] == kdat_f)
                kdat_cnt <= 16'h0000;
            else if (kdat_cnt == kb_bit_phase_cycle) begin
                kdat_f   <= kdat_s[1];
                kdat_cnt <= 16'h0000;
            end else
                kdat_cnt <= kdat_cnt + 16'd1;

            phase_cnt <= phase_tick ? 16'h0000 : phase_cnt + 16'd1;

            if (rd_done && rd_port == 8'h60)
                key_pending <= 1'b0;

            if (kclk_fall) begin
                timeout_cnt <= 16'h0000;
                if (bit_cnt == 4'd0) begin
                    if (!kdat_f)
                        bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {kdat_f, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity_bit <= kdat_f;
                    bit_cnt    <= 4'd10;
                end else begin
                    if (kdat_f && (^{shift, parity_bit})) begin
                        scancode    <= shift;
                        key_pending <= 1'b1;
                    end
                    bit_cnt <= 4'd0;
                end
            end else if (bit_cnt == 4'd0) begin
                timeout_cnt <= 16'h0000;
            end else if (phase_tick) begin
                if (timeout_cnt == kb_over_time) begin
                    timeout_cnt <= 16'h0000;
                    bit_cnt     <= 4'd0;
                end else
                    timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pcjr_peripherals.sv
// tb/tb_pcjr_peripherals.sv - self-checking bench for pcjr_peripherals
module tb_pcjr_peripherals;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_clock_posedge = 1'b1;
    logic        cpu_clock_negedge = 1'b0;
    logic        pclk_enable = 1'b0;
    logic        dcsg_clock_enable = 1'b0;
    logic [19:0] ADDRESS = 20'h0;
    logic [7:0]  DATA_IN = 8'h00;
    logic [7:0]  DATA_OUT;
    logic        X_IO_OR_M = 1'b0;
    logic        R_OR_DT = 1'b0;
    logic        IOR_N = 1'b1;
    logic        IOW_N = 1'b1;
    logic        MEMR_N = 1'b1;
    logic        MEMW_N = 1'b1;
    logic        IO_E = 1'b0;
    logic        SOUND_READY;
    logic        peripherals_data_out;
    logic        timer_intr;
    logic        timer_audio;
    logic [7:0]  audio_input = 8'h80;
    logic [7:0]  audio;
    logic        kbd_clk = 1'b1;
    logic        kbd_dat = 1'b1;
    logic        NMI;

    int checks = 0;
    int errors = 0;

    pcjr_peripherals #(.kb_bit_phase_cycle(16'd3), .kb_over_time(16'd40)) dut (
        .clock                (clock),
        .reset                (reset),
        .cpu_clock_posedge    (cpu_clock_posedge),
        .cpu_clock_negedge    (cpu_clock_negedge),
        .pclk_enable          (pclk_enable),
        .dcsg_clock_enable    (dcsg_clock_enable),
        .ADDRESS              (ADDRESS),
        .DATA_IN              (DATA_IN),
        .DATA_OUT             (DATA_OUT),
        .X_IO_OR_M            (X_IO_OR_M),
        .R_OR_DT              (R_OR_DT),
        .IOR_N                (IOR_N),
        .IOW_N                (IOW_N),
        .MEMR_N               (MEMR_N),
        .MEMW_N               (MEMW_N),
        .IO_E                 (IO_E),
        .SOUND_READY          (SOUND_READY),
        .peripherals_data_out (peripherals_data_out),
        .timer_intr           (timer_intr),
        .timer_audio          (timer_audio),
        .audio_input          (audio_input),
        .audio                (audio),
        .kbd_ps2_device_clock (kbd_clk),
        .kbd_ps2_device_data  (kbd_dat),
        .NMI                  (NMI)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            cpu_clock_negedge = ~cpu_clock_negedge;
            cpu_clock_posedge = ~cpu_clock_negedge;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        io;
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        exp_pdo;
        logic [7:0]  exp_data;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic io, input logic [19:0] a, output logic pdo, output logic [7:0] d);
        @(posedge clock); #1;
        ADDRESS = a; X_IO_OR_M = io; IO_E = 1'b1; IOR_N = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        pdo = peripherals_data_out;
        d   = DATA_OUT;
        @(posedge clock); #1;
        IOR_N = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        IO_E = 1'b0; X_IO_OR_M = 1'b0; ADDRESS = 20'h0;
    endtask

    task automatic do_write(input logic io, input logic [19:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        ADDRESS = a; DATA_IN = d; X_IO_OR_M = io; IO_E = 1'b1; IOW_N = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        IOW_N = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        IO_E = 1'b0; X_IO_OR_M = 1'b0; ADDRESS = 20'h0;
    endtask

    task automatic read_check(input string name, input logic [19:0] a, input logic [7:0] exp);
        logic       pdo;
        logic [7:0] d;
        do_read(1'b1, a, pdo, d);
        check({name, "_pdo"}, int'(pdo), 1);
        check(name, int'(d), int'(exp));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1; pclk_enable = 1'b1;
            @(posedge clock); #1; pclk_enable = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic dticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1; dcsg_clock_enable = 1'b1;
            @(posedge clock); #1; dcsg_clock_enable = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        kbd_dat = b;
        repeat (10) @(posedge clock);
        #1; kbd_clk = 1'b0;
        repeat (10) @(posedge clock);
        #1; kbd_clk = 1'b1;
        repeat (10) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic good_parity, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ ~good_parity, code, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(bits[i]);
        kbd_dat = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic       pdo;
        logic [7:0] d;

        vecs[0]  = '{1'b1, 1'b0, 20'h00040, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 20'h00040, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 20'h00061, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 20'h000A0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 20'h00060, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 20'h00010, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 20'h00061, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 20'h00061, 8'h02, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 20'h00061, 8'h00, 1'b1, 8'h02, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 20'h00161, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 20'h00061, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 20'h00061, 8'h00, 1'b1, 8'h02, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 20'h00061, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 20'h000C0, 8'h9F, 1'b0, 8'h00, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 20'h010C0, 8'h9F, 1'b0, 8'h00, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 20'h00061, 8'h00, 1'b1, 8'h00, 1'b1};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_data_out", int'(DATA_OUT), 0);
        check("rst_pdo", int'(peripherals_data_out), 0);
        check("rst_sound_ready", int'(SOUND_READY), 1);
        check("rst_timer_intr", int'(timer_intr), 0);
        check("rst_timer_audio", int'(timer_audio), 0);
        check("rst_audio", int'(audio), 0);
        check("rst_nmi", int'(NMI), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].io, vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read(vecs[i].io, vecs[i].addr, pdo, d);
                check($sformatf("vec%0d_pdo", i), int'(pdo), int'(vecs[i].exp_pdo));
                check($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
            end
            @(negedge clock);
            check($sformatf("vec%0d_ready", i), int'(SOUND_READY), int'(vecs[i].exp_ready));
        end
        check("pdo_idle", int'(peripherals_data_out), 0);

        // Counter 0: LSB/MSB pair with no control word, reload 0x55 = 85 ticks
        do_write(1'b1, 20'h00040, 8'h55);
        ticks(3);
        check("t0_not_started", int'(timer_intr), 0);
        do_write(1'b1, 20'h00040, 8'h00);
        @(negedge clock);
        check("t0_start_high", int'(timer_intr), 1);
        ticks(42);
        check("t0_k42_high", int'(timer_intr), 1);
        ticks(1);
        check("t0_k43_low", int'(timer_intr), 0);
        ticks(41);
        check("t0_k84_low", int'(timer_intr), 0);
        ticks(1);
        check("t0_k85_reload_high", int'(timer_intr), 1);
        ticks(10);
        do_write(1'b1, 20'h00043, 8'h00);
        ticks(5);
        read_check("t0_latch_lsb", 20'h00040, 8'h4B);
        read_check("t0_latch_msb", 20'h00040, 8'h00);
        read_check("t0_live_lsb", 20'h00040, 8'h46);
        read_check("t0_live_msb", 20'h00040, 8'h00);

        // Counter 2 at reload 4 gated onto the speaker
        do_write(1'b1, 20'h00043, 8'hB6);
        do_write(1'b1, 20'h00042, 8'h04);
        do_write(1'b1, 20'h00042, 8'h00);
        do_write(1'b1, 20'h00061, 8'h03);
        repeat (2) @(negedge clock);
        check("t2_audio_high0", int'(timer_audio), 1);
        check("mix_high0", int'(audio), 'h7F);
        ticks(1);
        check("t2_audio_high1", int'(timer_audio), 1);
        ticks(1);
        repeat (2) @(negedge clock);
        check("t2_audio_low2", int'(timer_audio), 0);
        check("mix_low2", int'(audio), 'h40);
        ticks(1);
        check("t2_audio_low3", int'(timer_audio), 0);
        ticks(1);
        repeat (2) @(negedge clock);
        check("t2_audio_high4", int'(timer_audio), 1);
        check("mix_high4", int'(audio), 'h7F);
        do_write(1'b1, 20'h00061, 8'h00);
        repeat (2) @(negedge clock);
        check("t2_audio_off", int'(timer_audio), 0);
        check("mix_off", int'(audio), 'h40);

        // Keyboard: good frame, bad parity, and a timed-out partial frame
        do_write(1'b1, 20'h000A0, 8'h80);
        send_frame(8'h1C, 1'b1, 11);
        check("kb_nmi_set", int'(NMI), 1);
        read_check("kb_nmi_ctrl", 20'h000A0, 8'h81);
        read_check("kb_scancode", 20'h00060, 8'h1C);
        @(negedge clock);
        check("kb_nmi_cleared", int'(NMI), 0);
        send_frame(8'h1C, 1'b0, 11);
        check("kb_bad_parity_nmi", int'(NMI), 0);
        read_check("kb_bad_parity_ctrl", 20'h000A0, 8'h80);
        send_frame(8'h33, 1'b1, 5);
        repeat (400) @(posedge clock);
        send_frame(8'h5A, 1'b1, 11);
        check("kb_after_timeout_nmi", int'(NMI), 1);
        read_check("kb_after_timeout_code", 20'h00060, 8'h5A);

        // DCSG handshake: 32 ticks busy, restart on a write while busy
        do_write(1'b1, 20'h000C0, 8'h9F);
        @(negedge clock);
        check("dcsg_busy", int'(SOUND_READY), 0);
        dticks(31);
        check("dcsg_busy31", int'(SOUND_READY), 0);
        dticks(1);
        check("dcsg_ready32", int'(SOUND_READY), 1);
        do_write(1'b1, 20'h000C0, 8'h9F);
        dticks(20);
        do_write(1'b1, 20'h000C0, 8'h9F);
        dticks(31);
        check("dcsg_restart_busy31", int'(SOUND_READY), 0);
        dticks(1);
        check("dcsg_restart_ready", int'(SOUND_READY), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcjr_peripherals.md
Name: pcjr_peripherals

Overview:
- I/O-mapped peripheral cluster for the PCjr core: bus decode and read mux; simplified 8253 timer (counters 0 and 2); port-B speaker control; PS/2 keyboard receiver with NMI latch; DCSG write handshake; audio mixer.
- Sits between the CPU bus interface and the external sound generator and keyboard.
- Memory cycles are never claimed.

Parameters:
- kb_bit_phase_cycle, 16'd1999: PS/2 input filter length minus one, in clock cycles; a line change is accepted after kb_bit_phase_cycle+1 stable cycles.
- kb_over_time, 16'd1000: frame abort timeout, in units of (kb_bit_phase_cycle+1) clock cycles, with no accepted PS/2 clock edge.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- cpu_clock_posedge / cpu_clock_negedge  in  1  one-cycle CPU clock phase strobes
- pclk_enable  in  1  timer count enable
- dcsg_clock_enable  in  1  DCSG clock tick
- ADDRESS  in  20  bus address
- DATA_IN  in  8  write data
- DATA_OUT  out  8  read data
- X_IO_OR_M  in  1  1 = I/O cycle
- R_OR_DT  in  1  unused
- IOR_N / IOW_N  in  1  I/O read/write strobes, active low
- MEMR_N / MEMW_N  in  1  ignored
- IO_E  in  1  bus cycle enable
- SOUND_READY  out  1  DCSG ready
- peripherals_data_out  out  1  high when DATA_OUT is valid for a decoded read
- timer_intr  out  1  counter 0 output (IRQ0)
- timer_audio  out  1  speaker square wave
- audio_input  in  8  DCSG sample
- audio  out  8  mixed audio
- kbd_ps2_device_clock / kbd_ps2_device_data  in  1  PS/2 lines
- NMI  out  1  keyboard NMI

Behaviour:
- Decode:
  - Access is active when IO_E=1, X_IO_OR_M=1 and ADDRESS[15:8]=0.
  - Ports: 0x40 = counter0, 0x42 = counter2, 0x43 = control, 0x60 = scancode, 0x61 = port B, 0xA0 = NMI control, 0xC0 = DCSG.
  - Other addresses are not claimed.
- Write:
  - Commits once per IOW_N assertion, at the first clock with cpu_clock_negedge=1 while the write is active.
  - A done flag blocks repeats until IOW_N returns high.
- Read:
  - DATA_OUT is registered on every clock while IOR_N=0 and the port is decoded; peripherals_data_out=1 in the same cycles, 0 otherwise, DATA_OUT=0 otherwise.
  - Read side effects apply once, on the IOR_N rising edge.
- Reset values: DATA_OUT=0, peripherals_data_out=0, SOUND_READY=1, timer_intr=0, timer_audio=0, audio=0, NMI=0, all registers 0, both counters' access mode = 11 (LSB then MSB), byte pointer = LSB.
- Timer control (0x43):
  - Bits 7:6 select the counter; only 00 and 10 are honoured.
  - Bits 5:4 = 00 latches the current count; 01 = LSB only, 10 = MSB only, 11 = LSB then MSB. A nonzero value stops the counter and resets the byte pointer.
  - Mode bits are ignored; both counters run as square-wave generators.
- Timer count write:
  - Loads bytes per the access mode.
  - When the final byte arrives, reload R is set and the counter starts at R; R=0 means 65536.
- Timer counting:
  - While running and gated, the counter decrements on each pclk_enable tick and reloads to R after reaching 1.
  - Output is 1 while count > R/2, else 0.
  - Counter 0 is always gated; counter 2 is gated by port B bit0.
- Timer read: returns the latched value if latched (latch clears after its bytes are read), else the live count, using the same byte pointer.
- timer_intr = counter0 output; timer_audio = counter2 output AND port B bit1.
- Port B (0x61): read/write register, bits 1:0 used.
- Keyboard:
  - Filtered PS/2 lines; sample data on each accepted clock falling edge.
  - Frame is 11 bits: start 0, 8 data LSB first, odd parity, stop 1.
  - A bad start, parity or stop bit, or a timeout, discards the frame.
  - A good frame stores the scancode and sets key_pending; a new frame overwrites it.
- Reading 0x60 returns the scancode and clears key_pending.
- 0xA0:
  - Write: bit7 = NMI enable.
  - Read: {nmi_en, 6'b0, key_pending}.
- NMI is registered: NMI = nmi_en & key_pending.
- DCSG (0xC0):
  - A write drops SOUND_READY for 32 dcsg_clock_enable ticks.
  - A write while busy restarts the count.
- Audio: audio = audio_input[7:1] + (timer_audio ? 8'h3F : 0), registered every clock; no overflow is possible.

Test Plan:
- Reset, then read 0x40 -> peripherals_data_out=1 during IOR_N low, DATA_OUT=0x00; timer_intr=0.
- Write 0x40=0x55 with no control word -> LSB stored, counter not started, timer_intr stays 0; write 0x00 to 0x40 -> R=0x0055, timer_intr toggles with period 85 pclk_enable ticks.
- Write 0x43=0xB6, 0x42=0x04, 0x42=0x00, 0x61=0x03 -> timer_audio high 2 ticks, low 2 ticks; audio alternates between audio_input>>1 and +0x3F. Write 0x61=0x00 -> timer_audio=0.
- Write 0xA0=0x80, then send PS/2 frame for 0x1C with good parity -> NMI=1; read 0x60 -> 0x1C, NMI=0 after IOR_N rises. Bad parity -> no NMI.
- Write 0xC0=0x9F -> SOUND_READY=0 for 32 dcsg_clock_enable ticks, then 1.
- Read unmapped 0x10, and memory cycles -> peripherals_data_out=0, no state change.
